// File: rtl/gft_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gft_pkg : shared types for the ADC capture front end               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package gft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } fe_state_t;

  localparam logic MODE_STROBE = 1'b0;
  localparam logic MODE_SYNC   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/adc_en_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | adc_en_sync : 2-flop ADC synchroniser with falling-edge strobe      |
// | detect, or single-register pass-through in sync mode. Rev 1.0       |
// +--------------------------------------------------------------------+
module adc_en_sync
  import gft_pkg::*;
#(
  parameter int DW_IN = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             mode,
  input  logic             adc_en,
  input  logic [DW_IN-1:0] adc_data,
  output logic             evt,
  output logic [DW_IN-1:0] evt_data
);

  logic             r1_en_q, r1_en_d;
  logic             r2_en_q, r2_en_d;
  logic             r3_en_q, r3_en_d;
  logic [DW_IN-1:0] r1_data_q, r1_data_d;
  logic [DW_IN-1:0] r2_data_q, r2_data_d;

  always_comb begin
    r1_en_d   = adc_en;
    r2_en_d   = r1_en_q;
    r3_en_d   = r2_en_q;
    r1_data_d = adc_data;
    r2_data_d = r1_data_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r1_en_q   <= 1'b0;
      r2_en_q   <= 1'b0;
      r3_en_q   <= 1'b0;
      r1_data_q <= '0;
      r2_data_q <= '0;
    end else begin
      r1_en_q   <= r1_en_d;
      r2_en_q   <= r2_en_d;
      r3_en_q   <= r3_en_d;
      r1_data_q <= r1_data_d;
      r2_data_q <= r2_data_d;
    end
  end

  // Strobe mode samples on the falling edge; the ADC holds its word through the low phase.
  always_comb begin
    if (mode == MODE_SYNC) begin
      evt      = r1_en_q;
      evt_data = r1_data_q;
    end else begin
      evt      = r3_en_q & ~r2_en_q;
      evt_data = r2_data_q;
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_sample_frontend.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | adc_sample_frontend : frames offset-binary ADC words into a signed  |
// | valid/first/last sample stream for the Goertzel bank. Rev 1.0       |
// +--------------------------------------------------------------------+
module adc_sample_frontend
  import gft_pkg::*;
#(
  parameter int DW_IN   = 8,
  parameter int DW_OUT  = 16,
  parameter int NSAMP_W = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               abort,
  input  logic               arm,
  input  logic               mode,
  input  logic [NSAMP_W-1:0] num_samp,
  input  logic               adc_en,
  input  logic [DW_IN-1:0]   adc_data,
  output logic               s_valid,
  output logic [DW_OUT-1:0]  s_data,
  output logic               s_first,
  output logic               s_last,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic [NSAMP_W-1:0] cnt
);

  localparam logic [NSAMP_W-1:0] CNT_ONE = NSAMP_W'(1);

  fe_state_t            state_q, state_d;
  logic [NSAMP_W-1:0]   cnt_q, cnt_d;
  logic [NSAMP_W-1:0]   num_q, num_d;
  logic                 mode_q, mode_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 s_valid_q, s_valid_d;
  logic                 s_first_q, s_first_d;
  logic                 s_last_q, s_last_d;
  logic                 done_q, done_d;
  logic [DW_OUT-1:0]    s_data_q, s_data_d;

  logic                 evt;
  logic [DW_IN-1:0]     evt_data;
  logic signed [DW_IN-1:0] conv;

  adc_en_sync #(.DW_IN(DW_IN)) u_sync (
    .clk      (clk),
    .rstn     (rstn),
    .mode     (mode_q),
    .adc_en   (adc_en),
    .adc_data (adc_data),
    .evt      (evt),
    .evt_data (evt_data)
  );

  // Offset binary to two's complement is just an MSB flip.
  assign conv = $signed({~evt_data[DW_IN-1], evt_data[DW_IN-2:0]});

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    num_d     = num_q;
    mode_d    = mode_q;
    cfg_err_d = cfg_err_q;
    s_valid_d = 1'b0;
    s_first_d = 1'b0;
    s_last_d  = 1'b0;
    done_d    = 1'b0;
    s_data_d  = s_data_q;

    if (abort) begin
      state_d   = IDLE;
      cnt_d     = '0;
      cfg_err_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm) begin
            if (num_samp != '0) begin
              state_d   = ARMED;
              num_d     = num_samp;
              mode_d    = mode;
              cnt_d     = '0;
              cfg_err_d = 1'b0;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        ARMED: begin
          if (evt) begin
            s_valid_d = 1'b1;
            s_first_d = 1'b1;
            s_data_d  = DW_OUT'(conv);
            cnt_d     = CNT_ONE;
            if (num_q == CNT_ONE) begin
              s_last_d = 1'b1;
              state_d  = DONE;
            end else begin
              state_d  = RUN;
            end
          end
        end
        RUN: begin
          if (evt) begin
            s_valid_d = 1'b1;
            s_data_d  = DW_OUT'(conv);
            cnt_d     = cnt_q + CNT_ONE;
            if (cnt_d == num_q) begin
              s_last_d = 1'b1;
              state_d  = DONE;
            end
          end
        end
        DONE: begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      num_q     <= '0;
      mode_q    <= MODE_STROBE;
      cfg_err_q <= 1'b0;
      s_valid_q <= 1'b0;
      s_first_q <= 1'b0;
      s_last_q  <= 1'b0;
      done_q    <= 1'b0;
      s_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      num_q     <= num_d;
      mode_q    <= mode_d;
      cfg_err_q <= cfg_err_d;
      s_valid_q <= s_valid_d;
      s_first_q <= s_first_d;
      s_last_q  <= s_last_d;
      done_q    <= done_d;
      s_data_q  <= s_data_d;
    end
  end

  assign s_valid = s_valid_q;
  assign s_data  = s_data_q;
  assign s_first = s_first_q;
  assign s_last  = s_last_q;
  assign done    = done_q;
  assign cfg_err = cfg_err_q;
  assign cnt     = cnt_q;
  assign busy    = (state_q == ARMED) || (state_q == RUN);

endmodule
`default_nettype wire
